// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with forwarding, load-use stall and flush/hold control
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int RADDR = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             hold_i,
  input  logic             flush_i,
  input  logic             id_valid_i,
  input  logic [XLEN-1:0]  id_rs1_data_i,
  input  logic [XLEN-1:0]  id_rs2_data_i,
  input  logic [XLEN-1:0]  id_imm_i,
  input  logic [RADDR-1:0] id_rs1_i,
  input  logic [RADDR-1:0] id_rs2_i,
  input  logic [RADDR-1:0] id_rd_i,
  input  logic [2:0]       id_alu_ctrl_i,
  input  logic             id_alusrc_i,
  input  logic             id_regwrite_i,
  input  logic             id_memread_i,
  input  logic             id_memwrite_i,
  input  logic             id_memtoreg_i,
  input  logic             id_branch_i,
  input  logic             exmem_regwrite_i,
  input  logic [RADDR-1:0] exmem_rd_i,
  input  logic [XLEN-1:0]  exmem_result_i,
  input  logic             memwb_regwrite_i,
  input  logic [RADDR-1:0] memwb_rd_i,
  input  logic [XLEN-1:0]  memwb_data_i,
  output logic             stall_o,
  output logic [XLEN-1:0]  opsrc1_o,
  output logic [XLEN-1:0]  opsrc2_o,
  output logic [2:0]       alu_ctrl_o,
  output logic [XLEN-1:0]  store_data_o,
  output logic [RADDR-1:0] ex_rd_o,
  output logic             ex_valid_o,
  output logic             ex_regwrite_o,
  output logic             ex_memread_o,
  output logic             ex_memwrite_o,
  output logic             ex_memtoreg_o,
  output logic             ex_branch_o
);
  logic             r_valid, r_alusrc, r_regwrite, r_memread, r_memwrite, r_memtoreg, r_branch;
  logic [2:0]       r_alu_ctrl;
  logic [RADDR-1:0] r_rs1, r_rs2, r_rd;
  logic [XLEN-1:0]  r_rs1_data, r_rs2_data, r_imm;
  logic             w_bubble, w_a_ex, w_a_wb, w_b_ex, w_b_wb;
  logic [XLEN-1:0]  w_fwd_a, w_fwd_b;

  // A bubble is all-zero content, so flush, stall and an invalid ID share one path
  assign w_bubble = flush_i | stall_o | ~id_valid_i;

  // Pipeline register: reset clears, hold freezes, otherwise load ID or a bubble
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid    <= 1'b0;
      r_alusrc   <= 1'b0;
      r_regwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_memwrite <= 1'b0;
      r_memtoreg <= 1'b0;
      r_branch   <= 1'b0;
      r_alu_ctrl <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
    end else if (!hold_i) begin
      r_valid    <= w_bubble ? 1'b0 : 1'b1;
      r_alusrc   <= w_bubble ? 1'b0 : id_alusrc_i;
      r_regwrite <= w_bubble ? 1'b0 : id_regwrite_i;
      r_memread  <= w_bubble ? 1'b0 : id_memread_i;
      r_memwrite <= w_bubble ? 1'b0 : id_memwrite_i;
      r_memtoreg <= w_bubble ? 1'b0 : id_memtoreg_i;
      r_branch   <= w_bubble ? 1'b0 : id_branch_i;
      r_alu_ctrl <= w_bubble ? '0 : id_alu_ctrl_i;
      r_rs1      <= w_bubble ? '0 : id_rs1_i;
      r_rs2      <= w_bubble ? '0 : id_rs2_i;
      r_rd       <= w_bubble ? '0 : id_rd_i;
      r_rs1_data <= w_bubble ? '0 : id_rs1_data_i;
      r_rs2_data <= w_bubble ? '0 : id_rs2_data_i;
      r_imm      <= w_bubble ? '0 : id_imm_i;
    end
  end

  // Load-use hazard; suppressed when flushed (ID discarded) or held (pipe already frozen)
  always_comb begin
    stall_o = r_memread & r_valid & id_valid_i & (r_rd != '0) &
              ((r_rd == id_rs1_i) | (r_rd == id_rs2_i)) & ~flush_i & ~hold_i;
  end

  // Forwarding: EX/MEM is the most recent writer and wins over MEM/WB; x0 never forwards
  always_comb begin
    w_a_ex  = exmem_regwrite_i & (exmem_rd_i != '0) & (exmem_rd_i == r_rs1);
    w_a_wb  = memwb_regwrite_i & (memwb_rd_i != '0) & (memwb_rd_i == r_rs1);
    w_b_ex  = exmem_regwrite_i & (exmem_rd_i != '0) & (exmem_rd_i == r_rs2);
    w_b_wb  = memwb_regwrite_i & (memwb_rd_i != '0) & (memwb_rd_i == r_rs2);
    w_fwd_a = w_a_ex ? exmem_result_i : w_a_wb ? memwb_data_i : r_rs1_data;
    w_fwd_b = w_b_ex ? exmem_result_i : w_b_wb ? memwb_data_i : r_rs2_data;
  end

  assign opsrc1_o      = w_fwd_a;
  assign opsrc2_o      = r_alusrc ? r_imm : w_fwd_b;
  assign store_data_o  = w_fwd_b;
  assign alu_ctrl_o    = r_alu_ctrl;
  assign ex_rd_o       = r_rd;
  assign ex_valid_o    = r_valid;
  assign ex_regwrite_o = r_regwrite;
  assign ex_memread_o  = r_memread;
  assign ex_memwrite_o = r_memwrite;
  assign ex_memtoreg_o = r_memtoreg;
  assign ex_branch_o   = r_branch;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed checks of forwarding, load-use stall, flush, hold and reset
module tb_id_ex_stage;
  logic        clk_i = 1'b0, rst_i = 1'b0, hold_i = 1'b0, flush_i = 1'b0, id_valid_i = 1'b0;
  logic [31:0] id_rs1_data_i = '0, id_rs2_data_i = '0, id_imm_i = '0;
  logic [4:0]  id_rs1_i = '0, id_rs2_i = '0, id_rd_i = '0;
  logic [2:0]  id_alu_ctrl_i = '0;
  logic        id_alusrc_i = 1'b0, id_regwrite_i = 1'b0, id_memread_i = 1'b0;
  logic        id_memwrite_i = 1'b0, id_memtoreg_i = 1'b0, id_branch_i = 1'b0;
  logic        exmem_regwrite_i = 1'b0, memwb_regwrite_i = 1'b0;
  logic [4:0]  exmem_rd_i = '0, memwb_rd_i = '0;
  logic [31:0] exmem_result_i = '0, memwb_data_i = '0;
  logic        stall_o;
  logic [31:0] opsrc1_o, opsrc2_o, store_data_o;
  logic [2:0]  alu_ctrl_o;
  logic [4:0]  ex_rd_o;
  logic        ex_valid_o, ex_regwrite_o, ex_memread_o, ex_memwrite_o, ex_memtoreg_o, ex_branch_o;
  int          passed = 0, total = 0;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .hold_i(hold_i), .flush_i(flush_i), .id_valid_i(id_valid_i),
    .id_rs1_data_i(id_rs1_data_i), .id_rs2_data_i(id_rs2_data_i), .id_imm_i(id_imm_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i), .id_rd_i(id_rd_i), .id_alu_ctrl_i(id_alu_ctrl_i),
    .id_alusrc_i(id_alusrc_i), .id_regwrite_i(id_regwrite_i), .id_memread_i(id_memread_i),
    .id_memwrite_i(id_memwrite_i), .id_memtoreg_i(id_memtoreg_i), .id_branch_i(id_branch_i),
    .exmem_regwrite_i(exmem_regwrite_i), .exmem_rd_i(exmem_rd_i), .exmem_result_i(exmem_result_i),
    .memwb_regwrite_i(memwb_regwrite_i), .memwb_rd_i(memwb_rd_i), .memwb_data_i(memwb_data_i),
    .stall_o(stall_o), .opsrc1_o(opsrc1_o), .opsrc2_o(opsrc2_o), .alu_ctrl_o(alu_ctrl_o),
    .store_data_o(store_data_o), .ex_rd_o(ex_rd_o), .ex_valid_o(ex_valid_o),
    .ex_regwrite_o(ex_regwrite_o), .ex_memread_o(ex_memread_o), .ex_memwrite_o(ex_memwrite_o),
    .ex_memtoreg_o(ex_memtoreg_o), .ex_branch_o(ex_branch_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                    input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                    input logic [2:0] ctrl, input logic asrc, input logic rw, input logic mr,
                    input logic mw, input logic mtr, input logic br);
    id_valid_i = v; id_rs1_i = rs1; id_rs2_i = rs2; id_rd_i = rd;
    id_rs1_data_i = d1; id_rs2_data_i = d2; id_imm_i = imm; id_alu_ctrl_i = ctrl;
    id_alusrc_i = asrc; id_regwrite_i = rw; id_memread_i = mr;
    id_memwrite_i = mw; id_memtoreg_i = mtr; id_branch_i = br;
  endtask

  task automatic idle();
    id(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    #3;
    chk("rst_valid", ex_valid_o, 0);
    chk("rst_regwrite", ex_regwrite_o, 0);
    chk("rst_memread", ex_memread_o, 0);
    chk("rst_alu_ctrl", alu_ctrl_o, 0);
    chk("rst_opsrc1", opsrc1_o, 0);
    chk("rst_stall", stall_o, 0);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    id(1, 5, 6, 8, 32'hDEAD, 3, 0, 3, 0, 1, 0, 0, 0, 0);
    tick();
    idle();
    exmem_regwrite_i = 1; exmem_rd_i = 5; exmem_result_i = 32'h10;
    #1;
    chk("fwd_exmem_a", opsrc1_o, 32'h10);
    chk("alu_ctrl_add", alu_ctrl_o, 3);
    chk("ex_rd_8", ex_rd_o, 8);
    chk("ex_regwrite_1", ex_regwrite_o, 1);
    chk("ex_valid_1", ex_valid_o, 1);
    chk("opsrc2_regdata", opsrc2_o, 3);
    memwb_regwrite_i = 1; memwb_rd_i = 5; memwb_data_i = 32'h20;
    #1;
    chk("fwd_exmem_priority", opsrc1_o, 32'h10);
    exmem_regwrite_i = 0;
    #1;
    chk("fwd_memwb_a", opsrc1_o, 32'h20);
    memwb_regwrite_i = 0;
    #1;
    chk("no_fwd_a", opsrc1_o, 32'hDEAD);
    tick();
    chk("invalid_bubble_valid", ex_valid_o, 0);
    chk("invalid_bubble_rw", ex_regwrite_o, 0);
    chk("invalid_bubble_data", opsrc1_o, 0);
    id(1, 1, 6, 9, 1, 9, 32'h44, 3, 1, 1, 0, 0, 0, 0);
    tick();
    idle();
    chk("alusrc_imm", opsrc2_o, 32'h44);
    chk("store_regdata", store_data_o, 9);
    exmem_regwrite_i = 1; exmem_rd_i = 6; exmem_result_i = 32'h77;
    #1;
    chk("store_fwd", store_data_o, 32'h77);
    chk("alusrc_imm_fwd", opsrc2_o, 32'h44);
    exmem_regwrite_i = 0;
    id(1, 0, 0, 3, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0);
    tick();
    idle();
    exmem_regwrite_i = 1; exmem_rd_i = 0; exmem_result_i = 32'h55;
    #1;
    chk("x0_no_fwd", opsrc1_o, 0);
    exmem_regwrite_i = 0;
    id(1, 0, 0, 7, 0, 0, 4, 3, 1, 1, 1, 0, 1, 0);
    tick();
    id(1, 1, 7, 9, 1, 32'h1234, 0, 3, 0, 1, 0, 0, 0, 0);
    #1;
    chk("lu_stall", stall_o, 1);
    chk("lu_ex_memread", ex_memread_o, 1);
    tick();
    chk("lu_stall_once", stall_o, 0);
    chk("lu_bubble_valid", ex_valid_o, 0);
    chk("lu_bubble_memread", ex_memread_o, 0);
    chk("lu_bubble_regwrite", ex_regwrite_o, 0);
    chk("lu_bubble_memtoreg", ex_memtoreg_o, 0);
    tick();
    memwb_regwrite_i = 1; memwb_rd_i = 7; memwb_data_i = 32'hBEEF;
    #1;
    chk("lu_fwd_memwb_b", opsrc2_o, 32'hBEEF);
    chk("lu_dep_rd", ex_rd_o, 9);
    chk("lu_dep_valid", ex_valid_o, 1);
    memwb_regwrite_i = 0;
    id(1, 0, 0, 0, 0, 0, 0, 3, 1, 1, 1, 0, 1, 0);
    tick();
    id(1, 0, 0, 2, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0);
    #1;
    chk("lw_x0_memread", ex_memread_o, 1);
    chk("lw_x0_no_stall", stall_o, 0);
    id(1, 0, 0, 7, 0, 0, 0, 3, 1, 1, 1, 0, 1, 0);
    tick();
    id(1, 7, 0, 9, 0, 0, 0, 3, 0, 1, 0, 0, 0, 1);
    flush_i = 1;
    #1;
    chk("flush_kills_stall", stall_o, 0);
    tick();
    flush_i = 0;
    #1;
    chk("flush_valid", ex_valid_o, 0);
    chk("flush_regwrite", ex_regwrite_o, 0);
    chk("flush_memread", ex_memread_o, 0);
    chk("flush_branch", ex_branch_o, 0);
    id(1, 0, 0, 7, 0, 0, 0, 3, 1, 1, 1, 0, 1, 0);
    tick();
    id(1, 7, 0, 9, 0, 0, 0, 3, 0, 1, 0, 0, 0, 0);
    hold_i = 1;
    #1;
    chk("hold_kills_stall", stall_o, 0);
    tick();
    chk("hold_keeps_load", ex_memread_o, 1);
    chk("hold_stall_low", stall_o, 0);
    hold_i = 0;
    #1;
    chk("release_stall", stall_o, 1);
    tick();
    idle();
    id(1, 2, 3, 12, 32'h111, 32'h222, 0, 5, 0, 1, 0, 0, 0, 0);
    tick();
    hold_i = 1;
    for (int i = 0; i < 3; i++) begin
      id(1, 4, 4, 5'(i + 1), 32'h300 + i, 0, 0, 1, 0, 1, 0, 1, 0, 0);
      tick();
      chk("hold_rd", ex_rd_o, 12);
      chk("hold_ctrl", alu_ctrl_o, 5);
      chk("hold_op1", opsrc1_o, 32'h111);
      chk("hold_memwrite", ex_memwrite_o, 0);
    end
    hold_i = 0;
    tick();
    chk("unhold_rd", ex_rd_o, 3);
    chk("unhold_ctrl", alu_ctrl_o, 1);
    chk("unhold_op1", opsrc1_o, 32'h302);
    chk("unhold_memwrite", ex_memwrite_o, 1);
    rst_i = 0;
    #1;
    chk("arst_valid", ex_valid_o, 0);
    chk("arst_regwrite", ex_regwrite_o, 0);
    chk("arst_memwrite", ex_memwrite_o, 0);
    chk("arst_ctrl", alu_ctrl_o, 0);
    chk("arst_op1", opsrc1_o, 0);
    chk("arst_rd", ex_rd_o, 0);
    rst_i = 1;
    tick();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
